// File: rtl/shared_reg_arbiter.sv
// Four-way round-robin arbiter that owns a shared WIDTH-bit register.
// The winner's data is loaded once per transaction and the requester releases the grant.
module shared_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    output logic [3:0]           gnt,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     Q,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            Q     <= '0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        win   <= pick;
                        gnt   <= 4'b0001 << pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[win]) begin
                        Q     <= din[win*WIDTH +: WIDTH];
                        ack   <= 4'b0001 << win;
                        ptr   <= win + 2'd1;
                        state <= WRITE;
                    end else begin
                        // Requester withdrew: no load, pointer keeps its old value.
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    ack   <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!req[win]) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: expected grant/data pairs are queued at stimulus
// time and compared whenever the DUT pulses ack.
module tb_shared_reg_arbiter;

    localparam int WIDTH = 8;

    typedef struct {
        logic [3:0]       mask;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           req;
    logic [4*WIDTH-1:0]   din;
    logic [3:0]           gnt;
    logic [3:0]           ack;
    logic [WIDTH-1:0]     Q;
    logic                 busy;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   auto_drop = 1'b1;
    bit   rearm_en  = 1'b0;
    int   rearm_cnt[4];

    shared_reg_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .ack   (ack),
        .Q     (Q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] mask, input logic [WIDTH-1:0] data);
        exp_t e;
        e.mask = mask;
        e.data = data;
        sb.push_back(e);
    endtask

    // One cycle: sample at the falling edge, score any ack, then model requester behaviour.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        check_eq("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
        check_eq("ack_within_gnt", 32'(ack & ~gnt), 32'd0);
        if (rearm_en) begin
            for (int i = 0; i < 4; i++) begin
                if (rearm_cnt[i] > 0) begin
                    rearm_cnt[i]--;
                    if (rearm_cnt[i] == 0) req[i] = 1'b1;
                end
            end
        end
        if (ack != 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("ack", 32'(ack), 32'(e.mask));
                check_eq("gnt_at_ack", 32'(gnt), 32'(e.mask));
                check_eq("q_at_ack", 32'(Q), 32'(e.data));
            end
            if (auto_drop) begin
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) begin
                        req[i] = 1'b0;
                        if (rearm_en) rearm_cnt[i] = 2;
                    end
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || busy) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rearm_cnt[i] = 0;
        reset = 1'b1;
        req   = 4'b1111;
        din   = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset with every requester asserted
        tick();
        tick();
        check_eq("rst_q", 32'(Q), 32'd0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Fairness: all held, each winner re-raises after its transaction
        push_exp(4'b0001, 8'h11);
        push_exp(4'b0010, 8'h22);
        push_exp(4'b0100, 8'h33);
        push_exp(4'b1000, 8'h44);
        push_exp(4'b0001, 8'h11);
        rearm_en = 1'b1;
        reset = 1'b0;
        while (sb.size() != 0 && checks < 2000) tick();
        rearm_en = 1'b0;
        for (int i = 0; i < 4; i++) rearm_cnt[i] = 0;
        req = 4'b0000;
        drain(20);

        // Single write with cycle-level timing (ptr = 1)
        din[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        push_exp(4'b0100, 8'hA5);
        tick();
        check_eq("sw_gnt_e0", 32'(gnt), 32'b0100);
        check_eq("sw_ack_e0", 32'(ack), 32'd0);
        check_eq("sw_busy_e0", 32'(busy), 32'd1);
        tick();
        check_eq("sw_q_e1", 32'(Q), 32'hA5);
        tick();
        check_eq("sw_ack_e2", 32'(ack), 32'd0);
        check_eq("sw_gnt_e2", 32'(gnt), 32'b0100);
        tick();
        check_eq("sw_gnt_e3", 32'(gnt), 32'd0);
        check_eq("sw_busy_e3", 32'(busy), 32'd0);
        drain(20);

        // Pointer wrap: 3 wins (ptr -> 0), then 1001 grants 0 before 3
        req = 4'b1000;
        push_exp(4'b1000, 8'h44);
        drain(20);
        req = 4'b1001;
        push_exp(4'b0001, 8'h11);
        push_exp(4'b1000, 8'h44);
        drain(30);

        // Move ptr to 1 so a wrongly advanced pointer picks a different winner
        req = 4'b0001;
        push_exp(4'b0001, 8'h11);
        drain(20);

        // Abort in GRANT
        req = 4'b0010;
        tick();
        check_eq("ab_gnt_e0", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick();
        check_eq("ab_gnt", 32'(gnt), 32'd0);
        check_eq("ab_ack", 32'(ack), 32'd0);
        check_eq("ab_busy", 32'(busy), 32'd0);
        check_eq("ab_q", 32'(Q), 32'h11);
        req = 4'b0011;
        push_exp(4'b0010, 8'h22);
        push_exp(4'b0001, 8'h11);
        drain(30);

        // Reset in RELEASE while Q holds A5 (requester keeps req high)
        auto_drop = 1'b0;
        req = 4'b0100;
        push_exp(4'b0100, 8'hA5);
        tick();
        tick();
        tick();
        tick();
        check_eq("rm_busy", 32'(busy), 32'd1);
        check_eq("rm_q", 32'(Q), 32'hA5);
        check_eq("rm_gnt", 32'(gnt), 32'b0100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rm_async_q", 32'(Q), 32'd0);
        check_eq("rm_async_gnt", 32'(gnt), 32'd0);
        check_eq("rm_async_ack", 32'(ack), 32'd0);
        check_eq("rm_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        auto_drop = 1'b1;
        din[2*WIDTH +: WIDTH] = 8'h33;
        req = 4'b1100;
        reset = 1'b0;
        // ptr back at 0 selects requester 2; a stale ptr of 3 would select requester 3
        push_exp(4'b0100, 8'h33);
        drain(20);
        req = 4'b0000;
        drain(20);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
